// File: rtl/bios_load_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bios_load_pkg
// Brief    : Shared defaults, FIFO entry type and FSM states for the BIOS sink.
// Revision : 1.0
// ============================================================================
package bios_load_pkg;

    localparam int          DEF_WORDS     = 8192;
    localparam int          DEF_MEM_AW    = 19;
    localparam logic [18:0] DEF_BASE_ADDR = 19'h7E000;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } bios_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bios_load_sink_if.sv
`default_nettype none
// ============================================================================
// Module   : bios_load_sink_if
// Brief    : Loader handshake, SDRAM write port and status bundle of the sink.
// Revision : 1.0
// ============================================================================
interface bios_load_sink_if #(
    parameter int MEM_AW = 19
) ();

    logic              bios_start;
    logic [12:0]       bios_addr;
    logic [15:0]       bios_din;
    logic              bios_wr;
    logic              bios_req;
    logic              mem_req;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_dout;
    logic              mem_ack;
    logic              bios_done;
    logic              cpu_reset;
    logic              overflow;
    logic [13:0]       word_count;
    logic [15:0]       checksum;

    // master: loader + memory controller side; slave: the sink itself
    modport master (
        output bios_start, bios_addr, bios_din, bios_wr, mem_ack,
        input  bios_req, mem_req, mem_addr, mem_dout,
        input  bios_done, cpu_reset, overflow, word_count, checksum
    );

    modport slave (
        input  bios_start, bios_addr, bios_din, bios_wr, mem_ack,
        output bios_req, mem_req, mem_addr, mem_dout,
        output bios_done, cpu_reset, overflow, word_count, checksum
    );

endinterface
`default_nettype wire

// File: rtl/bios_load_sink_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bios_load_fifo
// Brief    : DEPTH-entry FIFO of {addr,data} words with synchronous flush.
// Revision : 1.0
// ============================================================================
module bios_load_fifo
    import bios_load_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  bios_entry_t                din_i,
    input  logic                       pop_i,
    output bios_entry_t                dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int            AW     = $clog2(DEPTH);
    localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

    bios_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == C_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/bios_load_sink.sv
`default_nettype none
// ============================================================================
// Module   : bios_load_sink
// Brief    : Accepts BIOS words from the loader, writes them to SDRAM, releases CPU.
// Revision : 1.0
// ============================================================================
module bios_load_sink
    import bios_load_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter int                WORDS     = DEF_WORDS,
    parameter int                MEM_AW    = DEF_MEM_AW,
    parameter logic [MEM_AW-1:0] BASE_ADDR = MEM_AW'(DEF_BASE_ADDR)
) (
    input logic             clk_sdr,
    input logic             reset_n,
    bios_load_sink_if.slave bus
);

    localparam int             CW        = $clog2(DEPTH) + 1;
    localparam logic [13:0]    C_WORDS   = 14'(WORDS);
    localparam logic [CW-1:0]  C_REQ_LIM = CW'(DEPTH - 1);

    state_t            state_q, state_d;
    logic              wr_q;
    logic              bios_req_q, bios_req_d;
    logic              mem_req_q, mem_req_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_dout_q, mem_dout_d;
    logic              done_q, done_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              overflow_q, overflow_d;
    logic [13:0]       word_count_q, word_count_d;
    logic [15:0]       checksum_q, checksum_d;

    logic              accept;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     fifo_count_eff;
    bios_entry_t       push_entry;
    bios_entry_t       head_entry;

    assign accept     = bus.bios_wr & ~wr_q & ~done_q;
    assign fifo_push  = accept & ~bus.bios_start;
    assign fifo_pop   = (state_q == ST_IDLE) & ~fifo_empty & ~done_q & ~bus.bios_start;
    assign fifo_drop  = fifo_push & fifo_full & ~fifo_pop;
    assign push_entry = '{addr: bus.bios_addr, data: bus.bios_din};
    assign fifo_count_eff = bus.bios_start ? '0 : fifo_count;

    bios_load_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_sdr),
        .rst_n   (reset_n),
        .flush_i (bus.bios_start),
        .push_i  (fifo_push),
        .din_i   (push_entry),
        .pop_i   (fifo_pop),
        .dout_o  (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        mem_dout_d   = mem_dout_q;
        done_d       = done_q;
        cpu_reset_d  = cpu_reset_q;
        overflow_d   = overflow_q | fifo_drop;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;

        unique case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    mem_addr_d = BASE_ADDR + MEM_AW'(head_entry.addr);
                    mem_dout_d = head_entry.data;
                    mem_req_d  = 1'b1;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (bus.mem_ack) begin
                    mem_req_d  = 1'b0;
                    checksum_d = checksum_q + mem_dout_q;
                    if (word_count_q != C_WORDS) word_count_d = word_count_q + 14'd1;
                    if (word_count_q + 14'd1 == C_WORDS) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                done_d      = 1'b1;
                cpu_reset_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        // Restart wins over anything else in flight, including a pending ack.
        if (bus.bios_start) begin
            state_d      = ST_IDLE;
            mem_req_d    = 1'b0;
            done_d       = 1'b0;
            cpu_reset_d  = 1'b1;
            overflow_d   = 1'b0;
            word_count_d = '0;
            checksum_d   = '0;
        end

        bios_req_d = ~done_d & (fifo_count_eff < C_REQ_LIM);
    end

    always_ff @(posedge clk_sdr or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wr_q         <= 1'b0;
            bios_req_q   <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_dout_q   <= '0;
            done_q       <= 1'b0;
            cpu_reset_q  <= 1'b1;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_q         <= bus.bios_wr;
            bios_req_q   <= bios_req_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_dout_q   <= mem_dout_d;
            done_q       <= done_d;
            cpu_reset_q  <= cpu_reset_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
        end
    end

    assign bus.bios_req   = bios_req_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_dout   = mem_dout_q;
    assign bus.bios_done  = done_q;
    assign bus.cpu_reset  = cpu_reset_q;
    assign bus.overflow   = overflow_q;
    assign bus.word_count = word_count_q;
    assign bus.checksum   = checksum_q;

endmodule
`default_nettype wire

// File: tb/tb_bios_load_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_bios_load_sink
// Brief    : Scoreboard bench for bios_load_sink: loader + acking memory model.
// Revision : 1.0
// ============================================================================
module tb_bios_load_sink;
    import bios_load_pkg::*;

    localparam logic [18:0] C_BASE = 19'h7E000;

    logic clk;
    logic rst_n;

    bios_load_sink_if #(.MEM_AW(19)) bus ();

    bios_load_sink #(
        .DEPTH     (4),
        .WORDS     (8192),
        .MEM_AW    (19),
        .BASE_ADDR (19'h7E000)
    ) dut (
        .clk_sdr (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bios_entry_t sb [$];
    int          n_req       = 0;
    int          model_count = 0;
    logic [15:0] model_sum   = '0;
    logic [15:0] cur_data    = '0;
    logic [18:0] last_addr   = '0;
    logic        req_prev    = 1'b0;
    bit          ack_en      = 1'b1;
    int          ack_delay   = 0;
    int          wait_cnt    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory side, run once per cycle on the falling edge: score new requests, drive acks.
    task automatic service();
        bios_entry_t e;
        if (!rst_n) begin
            req_prev    = 1'b0;
            bus.mem_ack = 1'b0;
            wait_cnt    = 0;
        end else begin
            if (bus.mem_req && !req_prev) begin
                n_req++;
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("mem_addr", 32'(bus.mem_addr), 32'(19'(C_BASE + 19'(e.addr))));
                    check_eq("mem_dout", 32'(bus.mem_dout), 32'(e.data));
                    cur_data  = e.data;
                    last_addr = bus.mem_addr;
                end
            end
            req_prev = bus.mem_req;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (bus.mem_req && ack_en) begin
                if (wait_cnt >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    model_count++;
                    model_sum   = model_sum + cur_data;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        service();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [12:0] a, input logic [15:0] d,
                             input bit wait_req, input bit expect_kept);
        int t;
        t = 0;
        if (wait_req) begin
            while (!bus.bios_req && t < 500) begin
                tick();
                t++;
            end
            if (t >= 500) check_eq("bios_req_timeout", 32'd0, 32'd1);
        end
        bus.bios_addr = a;
        bus.bios_din  = d;
        bus.bios_wr   = 1'b1;
        if (expect_kept) sb.push_back('{addr: a, data: d});
        tick();
        bus.bios_wr = 1'b0;
        tick();
    endtask

    task automatic wait_acks(input int n);
        int t;
        t = 0;
        while (model_count < n && t < 2000) begin
            tick();
            t++;
        end
        if (model_count < n) check_eq("ack_timeout", 32'(model_count), 32'(n));
    endtask

    task automatic pulse_start();
        bit saved;
        saved          = ack_en;
        ack_en         = 1'b0;
        bus.bios_start = 1'b1;
        tick();
        bus.bios_start = 1'b0;
        sb.delete();
        model_count = 0;
        model_sum   = '0;
        ack_en      = saved;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_bios_req"},   32'(bus.bios_req),   32'd0);
        check_eq({pfx, "_mem_req"},    32'(bus.mem_req),    32'd0);
        check_eq({pfx, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
        check_eq({pfx, "_mem_dout"},   32'(bus.mem_dout),   32'd0);
        check_eq({pfx, "_bios_done"},  32'(bus.bios_done),  32'd0);
        check_eq({pfx, "_cpu_reset"},  32'(bus.cpu_reset),  32'd1);
        check_eq({pfx, "_overflow"},   32'(bus.overflow),   32'd0);
        check_eq({pfx, "_word_count"}, 32'(bus.word_count), 32'd0);
        check_eq({pfx, "_checksum"},   32'(bus.checksum),   32'd0);
    endtask

    initial begin
        int base_req;
        bus.bios_start = 1'b0;
        bus.bios_addr  = '0;
        bus.bios_din   = '0;
        bus.bios_wr    = 1'b0;
        bus.mem_ack    = 1'b0;
        rst_n          = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        check_eq("req_after_rst", 32'(bus.bios_req), 32'd1);

        // Held-high write strobe must yield exactly one word.
        base_req      = n_req;
        bus.bios_addr = 13'd0;
        bus.bios_din  = 16'h1234;
        bus.bios_wr   = 1'b1;
        sb.push_back('{addr: 13'd0, data: 16'h1234});
        repeat (10) tick();
        bus.bios_wr = 1'b0;
        repeat (6) tick();
        check_eq("held_nreq",   32'(n_req - base_req), 32'd1);
        check_eq("held_count",  32'(bus.word_count),   32'd1);
        check_eq("held_cksum",  32'(bus.checksum),     32'h1234);
        check_eq("held_sbleft", 32'(sb.size()),        32'd0);

        // Slow memory: bios_req must fall once three words wait in the FIFO.
        pulse_start();
        check_eq("start_count", 32'(bus.word_count), 32'd0);
        ack_delay = 20;
        for (int i = 0; i < 3; i++) push_word(13'(i + 40), 16'(i * 16'h0111), 1'b1, 1'b1);
        check_eq("bp_req_hi", 32'(bus.bios_req), 32'd1);
        push_word(13'd43, 16'h0333, 1'b1, 1'b1);
        check_eq("bp_req_lo", 32'(bus.bios_req), 32'd0);
        for (int i = 4; i < 8; i++) push_word(13'(i + 40), 16'(i * 16'h0111), 1'b1, 1'b1);
        wait_acks(8);
        check_eq("bp_count", 32'(bus.word_count), 32'd8);
        check_eq("bp_cksum", 32'(bus.checksum),   32'(model_sum));
        check_eq("bp_ovf",   32'(bus.overflow),   32'd0);
        check_eq("bp_sb",    32'(sb.size()),      32'd0);

        // No acks: word 0 sits in WRITE, words 1-4 fill the FIFO, word 5 is dropped.
        ack_en    = 1'b0;
        ack_delay = 0;
        pulse_start();
        for (int i = 0; i < 6; i++) push_word(13'(i + 200), 16'hC000 + 16'(i), 1'b0, i < 5);
        check_eq("ovf_set", 32'(bus.overflow), 32'd1);
        ack_en = 1'b1;
        wait_acks(4);
        check_eq("ovf_count4", 32'(bus.word_count), 32'd4);
        wait_acks(5);
        check_eq("ovf_count5", 32'(bus.word_count), 32'd5);
        check_eq("ovf_cksum",  32'(bus.checksum),   32'(model_sum));
        check_eq("ovf_sticky", 32'(bus.overflow),   32'd1);
        check_eq("ovf_sb",     32'(sb.size()),      32'd0);
        pulse_start();
        check_eq("ovf_clear",  32'(bus.overflow),   32'd0);

        // Abort the load while word 100 is in WRITE.
        for (int i = 0; i < 100; i++) push_word(13'(i), 16'(i) ^ 16'hA5A5, 1'b1, 1'b1);
        wait_acks(100);
        ack_en = 1'b0;
        push_word(13'd100, 16'd100 ^ 16'hA5A5, 1'b1, 1'b1);
        check_eq("abort_inwrite", 32'(bus.mem_req),    32'd1);
        check_eq("abort_pre_cnt", 32'(bus.word_count), 32'd100);
        bus.bios_start = 1'b1;
        tick();
        bus.bios_start = 1'b0;
        check_eq("abort_memreq", 32'(bus.mem_req),    32'd0);
        check_eq("abort_count",  32'(bus.word_count), 32'd0);
        check_eq("abort_cpurst", 32'(bus.cpu_reset),  32'd1);
        check_eq("abort_cksum",  32'(bus.checksum),   32'd0);
        sb.delete();
        model_count = 0;
        model_sum   = '0;
        ack_en      = 1'b1;

        // Full image.
        for (int i = 0; i < 8192; i++) push_word(13'(i), 16'(i) ^ 16'hA5A5, 1'b1, 1'b1);
        wait_acks(8192);
        check_eq("full_done",   32'(bus.bios_done),  32'd1);
        check_eq("full_cpurst", 32'(bus.cpu_reset),  32'd0);
        check_eq("full_count",  32'(bus.word_count), 32'd8192);
        check_eq("full_cksum",  32'(bus.checksum),   32'(model_sum));
        check_eq("full_ovf",    32'(bus.overflow),   32'd0);
        check_eq("full_req",    32'(bus.bios_req),   32'd0);
        check_eq("full_last",   32'(last_addr),      32'h7FFFF);
        check_eq("full_sb",     32'(sb.size()),      32'd0);

        // Writes after completion are ignored entirely.
        base_req = n_req;
        push_word(13'd5, 16'hFFFF, 1'b0, 1'b0);
        repeat (4) tick();
        check_eq("done_nreq",  32'(n_req - base_req), 32'd0);
        check_eq("done_ovf",   32'(bus.overflow),     32'd0);
        check_eq("done_count", 32'(bus.word_count),   32'd8192);

        // Asynchronous reset mid-load, sampled before any further clock edge.
        pulse_start();
        ack_delay = 3;
        for (int i = 0; i < 5; i++) push_word(13'(i), 16'h5A00 + 16'(i), 1'b1, 1'b1);
        wait_acks(2);
        check_eq("arst_pre_cnt", 32'(bus.word_count != 14'd0), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        repeat (2) tick();
        rst_n = 1'b1;
        sb.delete();
        model_count = 0;
        model_sum   = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
